// File: rtl/uart_rx_fifo.sv
// UART receiver with programmable framing (5-8 data bits, optional parity, 1-2 stop bits)
// feeding a first-word-fall-through FIFO, with sticky framing/parity/overrun flags.
module uart_rx_fifo #(
    parameter int CLK_PER_BIT = 434,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun_err,
    input  logic                          err_clr
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_CNT  = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_CNT   = CW'(CLK_PER_BIT - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_IDLE} state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta, rxs;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_bad_q, par_bad_d;
    logic                   tick, char_done, fe_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_bad_d = par_bad_q;
        char_done = 1'b0;
        fe_set    = 1'b0;
        case (state_q)
            IDLE: if (!rxs) begin
                state_d   = START;
                cnt_d     = HALF_CNT;
                bit_d     = '0;
                par_bad_d = 1'b0;
            end
            START: if (!tick) cnt_d = cnt_q - CW'(1);
                   else if (rxs) state_d = IDLE;
                   else begin
                       state_d = DATA;
                       cnt_d   = BIT_CNT;
                   end
            DATA: if (!tick) cnt_d = cnt_q - CW'(1);
                  else begin
                      shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                      cnt_d   = BIT_CNT;
                      if (bit_q == LAST_DATA) begin
                          bit_d   = '0;
                          state_d = (PARITY == 0) ? STOP : PAR;
                      end else begin
                          bit_d = bit_q + 3'd1;
                      end
                  end
            PAR: if (!tick) cnt_d = cnt_q - CW'(1);
                 else begin
                     // even: data^parity must be 0; odd: must be 1
                     par_bad_d = (^shreg_q) ^ rxs ^ (PARITY == 1);
                     cnt_d     = BIT_CNT;
                     state_d   = STOP;
                 end
            STOP: if (!tick) cnt_d = cnt_q - CW'(1);
                  else if (!rxs) begin
                      fe_set  = 1'b1;
                      state_d = WAIT_IDLE;
                  end else if (bit_q == LAST_STOP) begin
                      char_done = 1'b1;
                      state_d   = IDLE;
                  end else begin
                      bit_d = bit_q + 3'd1;
                      cnt_d = BIT_CNT;
                  end
            WAIT_IDLE: if (rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_bad_q <= par_bad_d;
        end
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [AW-1:0]        rd_next;
    logic                 full, pop, push, pe_set, ov_set;

    assign count    = wr_ptr - rd_ptr;
    assign rd_valid = (count != '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign rd_next  = rd_ptr[AW-1:0] + AW'(1);
    assign pop      = rd_en && rd_valid;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push     = char_done && !par_bad_q && (!full || rd_en);
    assign pe_set   = char_done && par_bad_q;
    assign ov_set   = char_done && !par_bad_q && full && !rd_en;

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr[AW-1:0]] <= shreg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_data     <= '0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            // rd_data is a registered head copy so it holds its last value when empty
            if (pop) begin
                if (count > (AW+1)'(1)) rd_data <= mem[rd_next];
                else if (push)          rd_data <= shreg_q;
            end else if (push && !rd_valid) begin
                rd_data <= shreg_q;
            end
            frame_err   <= fe_set | (frame_err   & ~err_clr);
            parity_err  <= pe_set | (parity_err  & ~err_clr);
            overrun_err <= ov_set | (overrun_err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: instance A is 8N1 with a 4-deep FIFO, instance B is 7E2 with a
// 4-deep FIFO. Directed sequences, a parity/stop vector table, and a random run vs. a queue model.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_a = 1'b1, rd_en_a = 1'b0, err_clr_a = 1'b0;
    logic       rxd_b = 1'b1, rd_en_b = 1'b0, err_clr_b = 1'b0;
    logic [7:0] rd_data_a;
    logic [6:0] rd_data_b;
    logic       rd_valid_a, rd_valid_b;
    logic [2:0] count_a, count_b;
    logic       fe_a, pe_a, oe_a, fe_b, pe_b, oe_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .count(count_a), .frame_err(fe_a), .parity_err(pe_a),
        .overrun_err(oe_a), .err_clr(err_clr_a));

    uart_rx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .count(count_b), .frame_err(fe_b), .parity_err(pe_b),
        .overrun_err(oe_b), .err_clr(err_clr_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rst = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0; err_clr_a = 1'b0; err_clr_b = 1'b0;
        end
    endtask

    // Drives one frame; k counts cycles from the start bit, k == frame length is the stop sample cycle.
    task automatic send(input bit sel, input logic [7:0] d, input bit flip_par, input bit bad_stop,
                        input bit tail, input int rst_at, input int pop_at, input int clr_at);
        bit bits[$];
        bit b;
        int nb;
        bits.push_back(1'b0);
        if (!sel) begin
            for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        end else begin
            for (int i = 0; i < 7; i++) bits.push_back(d[i]);
            bits.push_back((^d[6:0]) ^ flip_par);
            bits.push_back(1'b1);
        end
        bits.push_back(!bad_stop);
        nb = bits.size() * 4;
        for (int k = 0; k <= nb; k++) begin
            @(negedge clk);
            b   = (k < nb) ? bits[k/4] : tail;
            rst = (k == rst_at);
            if (sel) begin
                rxd_b = b; rd_en_b = (k == pop_at); err_clr_b = (k == clr_at);
            end else begin
                rxd_a = b; rd_en_a = (k == pop_at); err_clr_a = (k == clr_at);
            end
        end
    endtask

    task automatic pop_a();
        @(negedge clk); rd_en_a = 1'b1;
        idle(1);
    endtask

    task automatic pop_b();
        @(negedge clk); rd_en_b = 1'b1;
        idle(1);
    endtask

    typedef struct {
        logic [6:0] d;
        bit flip, bad_stop, clr_s, exp_st, exp_pe, exp_fe;
    } vec_t;

    typedef struct {
        int s;
        bit bad;
        logic [7:0] d;
    } frame_t;

    vec_t       vecs[7];
    bit         wave[$];
    frame_t     fq[$];
    logic [7:0] mq[$];
    logic [7:0] last_d;
    bit         m_fe, m_oe;

    initial begin
        vecs[0] = '{7'h41, 0, 0, 0, 1, 0, 0};
        vecs[1] = '{7'h41, 1, 0, 0, 0, 1, 0};
        vecs[2] = '{7'h7F, 0, 0, 0, 1, 0, 0};
        vecs[3] = '{7'h00, 1, 0, 1, 0, 1, 0};
        vecs[4] = '{7'h2A, 0, 1, 0, 0, 0, 1};
        vecs[5] = '{7'h2A, 1, 1, 0, 0, 0, 1};
        vecs[6] = '{7'h55, 0, 0, 0, 1, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_valid_a", rd_valid_a, 0); chk("rst_count_a", count_a, 0);
        chk("rst_data_a", rd_data_a, 0);   chk("rst_flags_a", {fe_a, pe_a, oe_a}, 0);
        chk("rst_valid_b", rd_valid_b, 0); chk("rst_data_b", rd_data_b, 0);
        idle(4);

        // single 8N1 character, then pop
        send(0, 8'h55, 0, 0, 1, -1, -1, -1);
        idle(2);
        chk("t1_valid", rd_valid_a, 1); chk("t1_data", rd_data_a, 8'h55); chk("t1_count", count_a, 1);
        pop_a();
        chk("t1_pop_count", count_a, 0); chk("t1_pop_valid", rd_valid_a, 0);
        chk("t1_hold_data", rd_data_a, 8'h55);

        // overrun: fifth character lost
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 0, 0, 1, -1, -1, -1);
        idle(2);
        chk("t3_count", count_a, 4); chk("t3_ovr", oe_a, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("t3_order", rd_data_a, i);
            pop_a();
        end
        chk("t3_empty", rd_valid_a, 0);
        @(negedge clk); err_clr_a = 1'b1; idle(1);
        chk("t3_clr", oe_a, 0);

        // pop exactly at the fifth stop sample makes room
        for (int i = 1; i <= 4; i++) send(0, 8'(i), 0, 0, 1, -1, -1, -1);
        send(0, 8'h05, 0, 0, 1, -1, 40, -1);
        idle(2);
        chk("t3b_count", count_a, 4); chk("t3b_ovr", oe_a, 0);
        for (int i = 2; i <= 5; i++) begin
            chk("t3b_order", rd_data_a, i);
            pop_a();
        end

        // low stop bit followed by a break: one framing event only
        send(0, 8'h00, 0, 1, 0, -1, -1, -1);
        rxd_a = 1'b0; idle(40);
        chk("t4_fe", fe_a, 1); chk("t4_count", count_a, 0);
        @(negedge clk); err_clr_a = 1'b1; idle(80);
        chk("t4_no_refire", fe_a, 0); chk("t4_count2", count_a, 0);
        rxd_a = 1'b1; idle(4);
        send(0, 8'hA5, 0, 0, 1, -1, -1, -1);
        idle(2);
        chk("t4_next_data", rd_data_a, 8'hA5); chk("t4_next_count", count_a, 1);
        pop_a();

        // one-cycle glitch on idle line
        @(negedge clk); rxd_a = 1'b0;
        @(negedge clk); rxd_a = 1'b1;
        idle(20);
        chk("t5_count", count_a, 0); chk("t5_flags", {fe_a, pe_a, oe_a}, 0);

        // reset during data bits of 0xF0 (trailing bits high, so no false start afterwards)
        send(0, 8'h77, 0, 0, 1, -1, -1, -1);
        send(0, 8'h12, 0, 1, 1, -1, -1, -1);
        idle(4);
        chk("t6_pre_count", count_a, 1); chk("t6_pre_fe", fe_a, 1);
        send(0, 8'hF0, 0, 0, 1, 22, -1, -1);
        idle(4);
        chk("t6_count", count_a, 0); chk("t6_valid", rd_valid_a, 0);
        chk("t6_data", rd_data_a, 0); chk("t6_flags", {fe_a, pe_a, oe_a}, 0);
        send(0, 8'h3C, 0, 0, 1, -1, -1, -1);
        idle(2);
        chk("t6_next_data", rd_data_a, 8'h3C); chk("t6_next_count", count_a, 1);
        pop_a();

        // 7E2 vector table
        for (int v = 0; v < 7; v++) begin
            send(1, {1'b0, vecs[v].d}, vecs[v].flip, vecs[v].bad_stop, 1, -1, -1,
                 vecs[v].clr_s ? 44 : -1);
            idle(3);
            chk("vb_count", count_b, vecs[v].exp_st);
            if (vecs[v].exp_st) begin
                chk("vb_data", rd_data_b, vecs[v].d);
                pop_b();
            end
            chk("vb_pe", pe_b, vecs[v].exp_pe);
            chk("vb_fe", fe_b, vecs[v].exp_fe);
            chk("vb_oe", oe_b, 0);
            @(negedge clk); err_clr_b = 1'b1; idle(1);
            chk("vb_clr", {fe_b, pe_b}, 0);
        end

        // random frames against a queue model
        @(negedge clk); rst = 1'b1; rxd_a = 1'b1;
        idle(2);
        for (int i = 0; i < 8; i++) wave.push_back(1'b1);
        begin
            bit prev_bad = 0;
            for (int f = 0; f < 40; f++) begin
                frame_t fr;
                int gap;
                gap = prev_bad ? $urandom_range(4, 12) : $urandom_range(0, 12);
                repeat (gap) wave.push_back(1'b1);
                fr.s   = wave.size() + 40;
                fr.d   = 8'($urandom_range(0, 255));
                fr.bad = ($urandom_range(0, 5) == 0);
                repeat (4) wave.push_back(1'b0);
                for (int i = 0; i < 8; i++) repeat (4) wave.push_back(fr.d[i]);
                repeat (4) wave.push_back(!fr.bad);
                fq.push_back(fr);
                prev_bad = fr.bad;
            end
            repeat (60) wave.push_back(1'b1);
        end
        last_d = 8'h00; m_fe = 0; m_oe = 0;
        for (int c = 0; c < wave.size(); c++) begin
            bit pop, full, fe_set, ov_set, push;
            frame_t fr;
            @(negedge clk);
            chk("rnd_count", count_a, mq.size());
            chk("rnd_valid", rd_valid_a, mq.size() != 0);
            chk("rnd_data", rd_data_a, (mq.size() != 0) ? mq[0] : last_d);
            chk("rnd_fe", fe_a, m_fe);
            chk("rnd_oe", oe_a, m_oe);
            chk("rnd_pe", pe_a, 0);
            rxd_a     = wave[c];
            rd_en_a   = ($urandom_range(0, 7) == 0);
            err_clr_a = ($urandom_range(0, 39) == 0);
            pop = rd_en_a && (mq.size() != 0);
            full = (mq.size() == 4);
            fe_set = 0; ov_set = 0; push = 0;
            if (fq.size() != 0 && fq[0].s == c) begin
                fr = fq.pop_front();
                if (fr.bad)                  fe_set = 1;
                else if (full && !rd_en_a)   ov_set = 1;
                else                         push = 1;
            end
            if (pop)  last_d = mq.pop_front();
            if (push) mq.push_back(fr.d);
            m_fe = fe_set | (m_fe & !err_clr_a);
            m_oe = ov_set | (m_oe & !err_clr_a);
        end
        chk("rnd_all_frames_seen", fq.size(), 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
